sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream stage for the 4-bit adder: consumes its IN_W-bit result words over a
//  valid/ready handshake, accumulates N_BEATS of them into an ACC_W-bit total and
//  presents the total, with a sticky overflow flag, on an output valid/ready port.
//  Turns the combinational adder into a multi-beat summing datapath.
// PARAMETERS
//  IN_W     5                        width of incoming adder result (4-bit sum + carry)
//  ACC_W    12                       accumulator / out_total width
//  N_BEATS  4                        accepted beats per group (>=1)
//  CNT_W    $clog2(N_BEATS+1)        beat counter width (derived, do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  clear      in   1      synchronous abort of current group, returns to IDLE
//  in_valid   in   1      in_sum valid
//  in_ready   out  1      stage can accept a beat
//  in_sum     in   IN_W   adder result, unsigned
//  out_valid  out  1      out_total/out_ovf valid
//  out_ready  in   1      consumer accepts total
//  out_total  out  ACC_W  group sum modulo 2^ACC_W
//  out_ovf    out  1      sticky: any carry out of ACC_W during the group
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - rst_n low (async): state=IDLE, acc=0, cnt=0, out_valid=0, out_total=0, out_ovf=0, busy=0.
//  - Beat accepted iff in_valid && in_ready. in_ready = (state!=HOLD) && !clear (combinational).
//  - IDLE: on accept acc<=zext(in_sum), cnt<=1, ovf<=0; next = (N_BEATS==1) ? HOLD : ACCUM.
//  - ACCUM: on accept {carry,acc}<=acc+zext(in_sum); ovf<=ovf|carry; cnt<=cnt+1;
//    if cnt+1==N_BEATS -> HOLD. No accept -> hold all state (gaps allowed).
//  - HOLD: out_valid=1, out_total=acc, out_ovf=ovf; all stable until out_ready.
//    out_valid && out_ready -> IDLE, acc/cnt/ovf cleared next cycle. in_ready=0 in HOLD.
//  - Latency: out_valid rises the cycle after the N_BEATS-th accepted beat.
//    Minimum group period N_BEATS+1 cycles (with out_ready=1).
//  - Arithmetic: unsigned, wraps modulo 2^ACC_W; wrap sets out_ovf, never saturates.
//  - clear (highest sync priority, any state): next state IDLE, acc/cnt/ovf <= 0,
//    out_valid drops next cycle; a beat presented with clear is not accepted.
//    clear in HOLD with out_ready=1: treated as clear; the handshake does not count.
//  - rst_n asserted mid-group: group discarded, no partial output ever emitted.
//  - Outputs registered except in_ready, busy decoded from state register.
// STRUCTURE
//  - sum_accumulator_pkg: typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_e;
//    localparam defaults for IN_W/ACC_W/N_BEATS.
//  - No sub-module: one state/next-state FSM, one datapath always_ff (acc, cnt, ovf).
//  - Elaboration check: ACC_W >= IN_W, N_BEATS >= 1.
// TESTING (defaults unless stated)
//  1. Beats 3,18,0,30 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th beat,
//     out_total=51, out_ovf=0, in_ready=0 during that cycle, IDLE next.
//  2. ACC_W=6: beats 31,31,31,31 -> out_total=60 (124 mod 64), out_ovf=1; next group
//     1,1,1,1 -> out_total=4, out_ovf=0 (sticky cleared).
//  3. Backpressure: group 1,2,3,4 with out_ready=0 for 5 cycles -> out_valid/out_total=10
//     held stable, in_valid=1 ignored; out_ready=1 -> single transfer, back to IDLE.
//  4. Gaps: in_valid pattern 1,0,0,1,0,1,1 with sums 2,X,X,4,X,6,8 -> total 20, only
//     handshaken beats counted.
//  5. clear after beats 5,7 (same cycle as in_valid with 9) -> 9 dropped, IDLE;
//     then 1,1,1,1 -> out_total=4.
//  6. rst_n pulsed low between clock edges mid-ACCUM -> outputs 0 immediately,
//     busy=0; following group 2,2,2,2 -> out_total=8, out_ovf=0.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and default parameters for the multi-beat sum accumulator
// that sits downstream of the 4-bit adder.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int DEF_IN_W    = 5;
    localparam int DEF_ACC_W   = 12;
    localparam int DEF_N_BEATS = 4;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates N_BEATS adder results over a valid/ready input port and presents
// the group total plus a sticky overflow flag on a valid/ready output port.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int N_BEATS = DEF_N_BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_BEATS + 1);

    if (ACC_W < IN_W || N_BEATS < 1) begin : g_bad_params
        $error("sum_accumulator: requires ACC_W >= IN_W and N_BEATS >= 1");
    end

    acc_state_e       state_r;
    acc_state_e       state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             accept_s;
    logic [ACC_W:0]   sum_s;

    // The carry out of the ACC_W-bit add is what feeds the sticky overflow flag.
    assign sum_s     = {1'b0, acc_r} + {1'b0, ACC_W'(in_sum)};
    assign cnt_inc_s = cnt_r + CNT_W'(1);
    assign in_ready  = (state_r != HOLD) && !clear;
    assign accept_s  = in_valid && in_ready;
    assign busy      = (state_r != IDLE);

    // Next-state and datapath decode; clear overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        if (clear) begin
            state_nxt_s = IDLE;
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_nxt_s   = ACC_W'(in_sum);
                        cnt_nxt_s   = CNT_W'(1);
                        ovf_nxt_s   = 1'b0;
                        state_nxt_s = (N_BEATS == 1) ? HOLD : ACCUM;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_nxt_s = sum_s[ACC_W-1:0];
                        ovf_nxt_s = ovf_r | sum_s[ACC_W];
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_W'(N_BEATS)) begin
                            state_nxt_s = HOLD;
                        end else begin
                            state_nxt_s = ACCUM;
                        end
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt_s = IDLE;
                        acc_nxt_s   = {ACC_W{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        ovf_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; outputs load on the edge that enters HOLD
    // so they are valid in the same cycle the state reads HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_total <= {ACC_W{1'b0}};
            out_ovf   <= 1'b0;
        end else begin
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            ovf_r     <= ovf_nxt_s;
            out_valid <= (state_nxt_s == HOLD);
            out_total <= (state_nxt_s == HOLD) ? acc_nxt_s : {ACC_W{1'b0}};
            out_ovf   <= (state_nxt_s == HOLD) ? ovf_nxt_s : 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: directed groups plus random traffic against a group-sum
// reference model, on a default instance and an ACC_W=6 instance in lockstep.
module tb_sum_accumulator;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [4:0]  in_sum;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [11:0] out_total_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [5:0]  out_total_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: running true (unbounded) sum of the accepted beats.
    int m_sum  = 0;
    int m_cnt  = 0;
    bit m_hold = 1'b0;
    int e_tot12, e_ovf12, e_tot6, e_ovf6;

    always #5 clk = ~clk;

    sum_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_total(out_total_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    sum_accumulator #(.ACC_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_total(out_total_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_hold = 1'b0;
    endtask

    task automatic model_update();
        if (clear) begin
            model_reset();
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_sum += int'(in_sum);
            m_cnt++;
            if (m_cnt == NB) begin
                m_hold  = 1'b1;
                e_tot12 = m_sum % 4096;
                e_ovf12 = (m_sum >= 4096) ? 1 : 0;
                e_tot6  = m_sum % 64;
                e_ovf6  = (m_sum >= 64) ? 1 : 0;
                m_sum   = 0;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic check_all();
        logic exp_rdy;
        logic exp_busy;
        exp_rdy  = !m_hold && !clear;
        exp_busy = m_hold || (m_cnt > 0);
        check_eq("in_ready_a", 32'(in_ready_a), 32'(exp_rdy));
        check_eq("in_ready_b", 32'(in_ready_b), 32'(exp_rdy));
        check_eq("busy_a", 32'(busy_a), 32'(exp_busy));
        check_eq("busy_b", 32'(busy_b), 32'(exp_busy));
        check_eq("out_valid_a", 32'(out_valid_a), 32'(m_hold));
        check_eq("out_valid_b", 32'(out_valid_b), 32'(m_hold));
        if (m_hold) begin
            check_eq("out_total_a", 32'(out_total_a), 32'(e_tot12));
            check_eq("out_ovf_a", 32'(out_ovf_a), 32'(e_ovf12));
            check_eq("out_total_b", 32'(out_total_b), 32'(e_tot6));
            check_eq("out_ovf_b", 32'(out_ovf_b), 32'(e_ovf6));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cyc(input logic v, input logic [4:0] s, input logic c, input logic ordy);
        in_valid  = v;
        in_sum    = s;
        clear     = c;
        out_ready = ordy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = 5'd0; out_ready = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_total", 32'(out_total_a), 32'd0);
        check_eq("rst_ovf", 32'(out_ovf_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back group, immediate drain.
        cyc(1'b1, 5'd3, 1'b0, 1'b1);
        cyc(1'b1, 5'd18, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 5'd30, 1'b0, 1'b1);
        check_eq("t1_valid", 32'(out_valid_a), 32'd1);
        check_eq("t1_total", 32'(out_total_a), 32'd51);
        check_eq("t1_ovf", 32'(out_ovf_a), 32'd0);
        check_eq("t1_ready", 32'(in_ready_a), 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        check_eq("t1_idle", 32'(busy_a), 32'd0);

        // Wrap on the narrow instance, then sticky flag cleared by next group.
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd31, 1'b0, 1'b0);
        check_eq("t2_total6", 32'(out_total_b), 32'd60);
        check_eq("t2_ovf6", 32'(out_ovf_b), 32'd1);
        check_eq("t2_total12", 32'(out_total_a), 32'd124);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 1'b0, 1'b0);
        check_eq("t2b_total6", 32'(out_total_b), 32'd4);
        check_eq("t2b_ovf6", 32'(out_ovf_b), 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);

        // Backpressure: total held while in_valid is ignored.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 5'd7, 1'b0, 1'b0);
            check_eq("t3_hold_total", 32'(out_total_a), 32'd10);
        end
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        check_eq("t3_drained", 32'(out_valid_a), 32'd0);

        // Gaps between accepted beats.
        cyc(1'b1, 5'd2, 1'b0, 1'b0);
        cyc(1'b0, 5'(($urandom) & 32'd31), 1'b0, 1'b0);
        cyc(1'b0, 5'(($urandom) & 32'd31), 1'b0, 1'b0);
        cyc(1'b1, 5'd4, 1'b0, 1'b0);
        cyc(1'b0, 5'(($urandom) & 32'd31), 1'b0, 1'b0);
        cyc(1'b1, 5'd6, 1'b0, 1'b0);
        cyc(1'b1, 5'd8, 1'b0, 1'b0);
        check_eq("t4_total", 32'(out_total_a), 32'd20);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);

        // clear drops the coincident beat and aborts the group.
        cyc(1'b1, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, 5'd7, 1'b0, 1'b0);
        cyc(1'b1, 5'd9, 1'b1, 1'b0);
        check_eq("t5_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 1'b0, 1'b0);
        check_eq("t5_total", 32'(out_total_a), 32'd4);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-group.
        cyc(1'b1, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_busy", 32'(busy_a), 32'd0);
        check_eq("t6_valid", 32'(out_valid_a), 32'd0);
        check_eq("t6_total", 32'(out_total_a), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd2, 1'b0, 1'b0);
        check_eq("t6_total8", 32'(out_total_a), 32'd8);
        check_eq("t6_ovf", 32'(out_ovf_a), 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
